// File: rtl/stream_cipher_pkg.sv
// Shared types and constants for the byte stream cipher and decipher.
package stream_cipher_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t CTR_WRAP = 8'hFF;

   typedef enum logic [0:0] {NOKEY, RUN} dec_state_t;

endpackage

// File: rtl/stream_decipher_if.sv
// Byte stream valid/ready bundle; master drives data/valid, slave drives ready.
interface stream_decipher_if;
   import stream_cipher_pkg::*;

   byte_t data;
   logic  valid;
   logic  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox (
   input  logic [7:0] in,
   output logic [7:0] out
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] inv;
   logic [7:0] pw;

   always_comb begin
      inv = 8'h01;
      pw  = in;
      // x^254 is the inverse (and maps 0 to 0); 254 has every bit set except bit 0
      for (int i = 0; i < 8; i++) begin
         if (i != 0) inv = gf_mul(inv, pw);
         pw = gf_mul(pw, pw);
      end
      out = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/stream_decipher_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and synchronous flush;
// the read data holds its last shown value while empty.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     wr_en_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic                     rd_en_i,
   output logic [Width-1:0]         rdata_o,
   output logic [$clog2(Depth):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam logic [AddrW:0] PtrOne = 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
   logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] hold_q, hold_d;
   logic             do_wr, do_rd;

   assign level_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

   assign do_wr = wr_en_i && !full_o && !flush_i;
   assign do_rd = rd_en_i && !empty_o && !flush_i;

   assign rdata_o = empty_o ? hold_q : mem_q[rd_ptr_q[AddrW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      hold_d   = rdata_o;
      if (flush_i) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
         if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hold_q   <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/stream_decipher.sv
// Receive-side stream decipher: XORs ciphertext with sbox(counter) and buffers
// the plaintext in an output FIFO.
module stream_decipher
   import stream_cipher_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  byte_t                       key_i,
   input  logic                        key_in_i,
   stream_decipher_if.slave            cipher_if,
   stream_decipher_if.master           plain_if,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   dec_state_t state_q, state_d;
   byte_t      cb_q, cb_d;
   byte_t      ks;
   logic       accept;
   logic       fifo_full, fifo_empty;

   sbox u_sbox (
      .in  (cb_q),
      .out (ks)
   );

   assign cipher_if.ready = (state_q == RUN) && !fifo_full && !key_in_i;
   assign accept          = cipher_if.valid && cipher_if.ready;
   assign plain_if.valid  = !fifo_empty;

   sync_fifo #(
      .Width (8),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (key_in_i),
      .wr_en_i (accept),
      .wdata_i (cipher_if.data ^ ks),
      .rd_en_i (plain_if.valid && plain_if.ready),
      .rdata_o (plain_if.data),
      .level_o (fifo_level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      cb_d    = cb_q;
      if (key_in_i) begin
         state_d = RUN;
         cb_d    = key_i;
      end else if (accept) begin
         cb_d = (cb_q == CTR_WRAP) ? 8'h00 : cb_q + 8'h01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= NOKEY;
         cb_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cb_q    <= cb_d;
      end
   end

endmodule

// File: doc/stream_decipher.md
# stream_decipher

Receive-side counterpart of the byte stream cipher. It loads the same 8-bit key and regenerates the keystream `sbox(cb)` with an 8-bit wrapping counter. Each accepted ciphertext byte is XORed with the keystream to recover plaintext. Input and output use valid/ready handshakes, and a small first-word-fall-through output FIFO absorbs downstream backpressure, so the block can sit between a link receiver and a consumer that stalls.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output FIFO entries; a power of two, ≥ 2.

Ports:
- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `key`, in, 8: counter seed, sampled when `key_in` = 1.
- `key_in`, in, 1: load key and flush the FIFO.
- `din`, in, 8: ciphertext byte.
- `din_valid`, in, 1: `din` is valid.
- `din_ready`, out, 1: block accepts `din` this cycle.
- `dout`, out, 8: plaintext byte at the FIFO head.
- `dout_valid`, out, 1: FIFO is non-empty.
- `dout_ready`, in, 1: consumer takes `dout` this cycle.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- FSM with two states:
  - `NOKEY`: entered on reset.
  - `RUN`: entered on the edge where `key_in` = 1.
  - Nothing returns the FSM to `NOKEY` except `rst`.
- Counter `cb` (8 bits):
  - Reset value 0x00.
  - `key_in`: `cb <= key`.
  - Each accepted byte: `cb <= (cb == 0xFF) ? 0x00 : cb + 1`.
- Keystream: `ks = sbox(cb)`, combinational from the current `cb`.
- Accept: `din_valid && din_ready`. On accept, `din ^ ks` is pushed to the FIFO and `cb` advances.
- `din_ready` = (state == `RUN`) && (`fifo_level` < `FIFO_DEPTH`) && !`key_in`. It is combinational and never depends on `din_valid`.
- Pop: `dout_valid && dout_ready`.
- Push and pop may occur in the same cycle; `fifo_level` is unchanged when they do.
- `key_in` has priority over everything:
  - The FIFO is flushed: level becomes 0 and the head is discarded.
  - No accept occurs.
  - A pop presented in the same cycle still completes from the consumer's view, but its byte is dropped by the flush.
- Bytes are emitted strictly in acceptance order. A byte is never duplicated or lost except by flush or reset.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `din_ready` = 0
  - `dout_valid` = 0
  - `dout` = 0x00
  - `fifo_level` = 0
  - `cb` = 0x00
  - state = `NOKEY`
- `rst` takes effect mid-operation: FIFO contents and the key are lost, and the block re-enters `NOKEY`.
- Key load: `key_in` high on edge K puts the block in `RUN`; `din_ready` can be 1 from cycle K+1.
- Latency: a byte accepted on edge N is visible with `dout_valid` = 1 in cycle N+1, when the FIFO was empty.
- Full: with `fifo_level` == `FIFO_DEPTH`, `din_ready` = 0, even if a pop occurs that cycle. Space freed by a pop is usable from the next cycle.
- Empty: `dout_valid` = 0 and `dout` holds its last value. Consumers must not rely on `dout` while `dout_valid` is low.
- Counter wrap: the byte after the one using `cb` = 0xFF uses `cb` = 0x00.
- Back-to-back accepts sustain one byte per cycle while the FIFO is not full.

## Structure
- Shared package `stream_cipher_pkg` holds:
  - `byte_t` (8-bit typedef)
  - `CTR_WRAP` = 8'hFF
  - the state enum `dec_state_t {NOKEY, RUN}`
- Reuse the existing `sbox` module (`in`/`out`, 8 bits) unmodified.
- One natural sub-module, `sync_fifo`:
  - Parameterised by width and depth.
  - Power-of-two pointers with an extra wrap bit.
  - Provides `level`, `full` and `empty`, plus a synchronous `flush` input.

## Test plan
- Reset and no key: assert `rst` for 2 cycles, then drive `din_valid` = 1 with no key load. Required: `din_ready`, `dout_valid` and `fifo_level` all stay 0; nothing is emitted.
- Round trip:
  - Load key 0x3C into both the encrypting stream cipher and this block.
  - Encrypt 0x48, 0x45, 0x4C, 0x4C, 0x4F ("HELLO").
  - Feed the ciphertext into this block with `dout_ready` = 1.
  - Required: `dout` reproduces the same five bytes, each one cycle after its accept.
- Counter wrap: load key 0xFE and send three 0x00 bytes. Required: `dout` = sbox(0xFE), sbox(0xFF), sbox(0x00), in that order.
- Backpressure (`FIFO_DEPTH` = 4):
  - Hold `dout_ready` = 0 and offer six bytes.
  - Required: exactly four are accepted, then `din_ready` = 0 with `fifo_level` = 4.
  - Raise `dout_ready`: the four bytes drain in order, the remaining two are accepted, and `cb` advances by exactly 6 in total.
- Rekey mid-stream:
  - With 3 bytes buffered, pulse `key_in` with key 0x10 while `din_valid` = 1.
  - Required: `fifo_level` → 0 and no accept in that cycle.
  - The next byte 0xAA decrypts to 0xAA ^ sbox(0x10).
- Reset mid-operation: with the FIFO at 2 entries, pulse `rst` for 1 cycle. Required: all outputs are at their reset values the next cycle, the FSM is back in `NOKEY`, and `din_ready` stays 0 until the next `key_in`.
